// File: rtl/pdm_sample_feeder_if.sv
// Sample stream handshake from the bus/DMA side into the PDM sample feeder.
interface pdm_sample_feeder_if #(
    parameter int unsigned SAMPLE_WIDTH = 8
);
    logic [SAMPLE_WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pdm_sample_feeder.sv
// Rate-controlled sample source for the PDM: FIFO-buffered input, one sample per
// divider tick with zero-order hold, midscale silence and sticky flag on starvation.
module pdm_sample_feeder #(
    parameter int unsigned SAMPLE_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4,
    parameter int unsigned DIV_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    pdm_sample_feeder_if.slave         bus,
    input  logic [DIV_WIDTH-1:0]       rate_div,
    input  logic                       enable,
    input  logic                       underrun_clr,
    output logic [SAMPLE_WIDTH-1:0]    sample,
    output logic                       sample_strobe,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
    output logic                       underrun
);
    localparam int unsigned DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned LEVEL_W = FIFO_DEPTH_LOG2 + 1;
    localparam logic [LEVEL_W-1:0]      LEVEL_FULL = LEVEL_W'(DEPTH);
    localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE   = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    logic [SAMPLE_WIDTH-1:0]    mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [LEVEL_W-1:0]         level;
    logic [LEVEL_W-1:0]         level_next;
    logic                       ready_q;
    logic [DIV_WIDTH-1:0]       div_cnt;

    logic push;
    logic pop;
    logic tick;

    assign bus.in_ready = ready_q;
    assign fifo_level   = level;

    // Handshake, tick and occupancy decode from registered state.
    always_comb begin
        push       = bus.in_valid && ready_q;
        tick       = enable && (div_cnt == rate_div);
        pop        = tick && (level != '0);
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LEVEL_W'(1);
            2'b01:   level_next = level - LEVEL_W'(1);
            default: level_next = level;
        endcase
    end

    // Storage carries no reset; only pointers and level define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            ready_q       <= 1'b1;
            div_cnt       <= '0;
            sample        <= MIDSCALE;
            sample_strobe <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
            end
            level   <= level_next;
            ready_q <= (level_next != LEVEL_FULL);

            if (!enable || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_WIDTH'(1);
            end

            sample_strobe <= tick;
            if (tick) begin
                sample <= pop ? mem[rd_ptr] : MIDSCALE;
            end

            // A starved tick outranks a concurrent clear.
            if (tick && !pop) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pdm_sample_feeder.sv
// Scoreboard bench for pdm_sample_feeder: directed stimulus queues expected strobes,
// a negedge monitor checks value, underrun flag and arrival cycle of every strobe.
module tb_pdm_sample_feeder;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rate_div;
    logic        enable;
    logic        underrun_clr;
    logic [7:0]  sample;
    logic        sample_strobe;
    logic [4:0]  fifo_level;
    logic        underrun;

    int cyc    = 0;
    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] s;
        logic       u;
        int         c;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    pdm_sample_feeder_if #(.SAMPLE_WIDTH(8)) bus ();

    pdm_sample_feeder #(
        .SAMPLE_WIDTH(8),
        .FIFO_DEPTH_LOG2(4),
        .DIV_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .rate_div(rate_div),
        .enable(enable),
        .underrun_clr(underrun_clr),
        .sample(sample),
        .sample_strobe(sample_strobe),
        .fifo_level(fifo_level),
        .underrun(underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic expect_strobe(input logic [7:0] s, input logic u, input int c);
        exp_t x;
        x.s = s;
        x.u = u;
        x.c = c;
        sb.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic push(input logic [7:0] d);
        logic accepted;
        accepted = 1'b0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            accepted = bus.in_ready;
            step();
            if (accepted) break;
        end
        if (!accepted) begin
            total++;
            $display("FAIL push_timeout: data 0x%0h not accepted", d);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && sample_strobe) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_strobe: sample 0x%0h at cycle %0d, expected none",
                         sample, cyc);
            end else begin
                e = sb.pop_front();
                check("strobe_sample", int'(sample), int'(e.s));
                check("strobe_underrun", int'(underrun), int'(e.u));
                check("strobe_cycle", cyc, e.c);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int j;
        int p;
        int q;
        int r;
        int s;
        int u;

        reset        = 1'b0;
        rate_div     = 16'd3;
        enable       = 1'b0;
        underrun_clr = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        check("init_in_ready", int'(bus.in_ready), 1);
        check("init_level", int'(fifo_level), 0);
        check("init_sample", int'(sample), 32'h80);
        check("init_underrun", int'(underrun), 0);

        // Basic stream at rate_div=3
        push(8'h10);
        push(8'h20);
        push(8'h30);
        check("basic_level", int'(fifo_level), 3);
        k = cyc;
        enable = 1'b1;
        expect_strobe(8'h10, 1'b0, k + 4);
        expect_strobe(8'h20, 1'b0, k + 8);
        expect_strobe(8'h30, 1'b0, k + 12);
        expect_strobe(8'h80, 1'b1, k + 16);
        wait_to(k + 16);
        enable = 1'b0;
        check("basic_underrun_sticky", int'(underrun), 1);
        pulse_clr();
        check("clr_alone_1", int'(underrun), 0);

        // Fill to full, hold off a 17th word, then drain at rate_div=0
        for (int i = 0; i < 16; i++) push(8'(i));
        check("full_level", int'(fifo_level), 16);
        check("full_in_ready", int'(bus.in_ready), 0);
        bus.in_data  = 8'h10;
        bus.in_valid = 1'b1;
        repeat (3) step();
        check("held_in_ready", int'(bus.in_ready), 0);
        check("held_level", int'(fifo_level), 16);
        rate_div = 16'd0;
        j = cyc;
        enable = 1'b1;
        for (int i = 0; i < 17; i++) expect_strobe(8'(i), 1'b0, j + 1 + i);
        expect_strobe(8'h80, 1'b1, j + 18);
        step();
        check("ready_after_pop", int'(bus.in_ready), 1);
        check("level_after_pop", int'(fifo_level), 15);
        step();
        bus.in_valid = 1'b0;
        check("level_push_pop", int'(fifo_level), 15);
        wait_to(j + 18);
        enable = 1'b0;
        pulse_clr();
        check("clr_alone_2", int'(underrun), 0);

        // Push racing a tick on an empty FIFO, then sticky-set vs clear
        rate_div = 16'd3;
        p = cyc;
        enable = 1'b1;
        expect_strobe(8'h80, 1'b1, p + 4);
        expect_strobe(8'h55, 1'b1, p + 8);
        expect_strobe(8'h80, 1'b1, p + 12);
        wait_to(p + 3);
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("race_level", int'(fifo_level), 1);
        check("race_underrun", int'(underrun), 1);
        wait_to(p + 11);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        enable = 1'b0;
        check("set_beats_clr", int'(underrun), 1);
        step();
        pulse_clr();
        check("clr_alone_3", int'(underrun), 0);

        // Enable gating with 0x20 on the output and three words queued
        push(8'h10);
        push(8'h20);
        push(8'h30);
        push(8'h40);
        push(8'h50);
        rate_div = 16'd1;
        q = cyc;
        enable = 1'b1;
        expect_strobe(8'h10, 1'b0, q + 2);
        expect_strobe(8'h20, 1'b0, q + 4);
        wait_to(q + 4);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat (3) step();
            check("gated_sample", int'(sample), 32'h20);
            check("gated_level", int'(fifo_level), 3);
        end
        r = cyc;
        enable = 1'b1;
        expect_strobe(8'h30, 1'b0, r + 2);
        expect_strobe(8'h40, 1'b0, r + 4);
        expect_strobe(8'h50, 1'b0, r + 6);
        expect_strobe(8'h80, 1'b1, r + 8);
        wait_to(r + 8);
        enable = 1'b0;

        // Asynchronous reset mid-stream with words queued
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        push(8'hA4);
        push(8'hA5);
        s = cyc;
        enable = 1'b1;
        expect_strobe(8'hA1, 1'b1, s + 2);
        wait_to(s + 2);
        check("pre_reset_level", int'(fifo_level), 4);
        @(negedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        check("rst_sample", int'(sample), 32'h80);
        check("rst_level", int'(fifo_level), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_strobe", int'(sample_strobe), 0);
        repeat (2) step();
        reset = 1'b1;
        step();
        check("post_rst_in_ready", int'(bus.in_ready), 1);
        check("post_rst_level", int'(fifo_level), 0);
        rate_div = 16'd3;
        u = cyc;
        enable = 1'b1;
        expect_strobe(8'h80, 1'b1, u + 4);
        wait_to(u + 4);
        enable = 1'b0;
        repeat (4) step();
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pdm_sample_feeder.md
Name: pdm_sample_feeder

Overview:
Rate-controlled sample source that feeds the 8-bit pulse density modulator.
- Accepts samples from the bus/DMA side over a valid/ready handshake and buffers them in a small FIFO.
- Releases one sample per programmable rate tick and holds it on the `sample` output between ticks (zero-order hold).
- On starvation it outputs midscale silence and flags a sticky underrun.

Parameters:
- SAMPLE_WIDTH, 8: width of `in_data` and `sample`; matches the PDM input width.
- FIFO_DEPTH_LOG2, 4: log2 of FIFO depth; default depth is 16 entries.
- DIV_WIDTH, 16: width of the rate divider and of `rate_div`.

Ports:
- clk  in  1  system clock; same clock as the PDM.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  SAMPLE_WIDTH  incoming unsigned offset-binary sample.
- in_valid  in  1  `in_data` is valid.
- in_ready  out  1  FIFO can accept a word.
- rate_div  in  DIV_WIDTH  tick period is rate_div+1 clocks.
- enable  in  1  run the divider and the output updates.
- underrun_clr  in  1  clears the sticky underrun flag.
- sample  out  SAMPLE_WIDTH  held sample to the PDM; registered.
- sample_strobe  out  1  one-cycle pulse when `sample` takes a new value.
- fifo_level  out  FIFO_DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- underrun  out  1  sticky: a tick found the FIFO empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - sample = midscale, i.e. 1 followed by SAMPLE_WIDTH-1 zeros (0x80 by default).
  - sample_strobe = 0, underrun = 0, fifo_level = 0, divider = 0, FIFO pointers = 0.
  - in_ready = 1 once reset is released.
- FIFO:
  - Dual-pointer with DEPTH entries; pointers are FIFO_DEPTH_LOG2 wide and wrap modulo DEPTH.
  - in_ready = (fifo_level != DEPTH), decoded from registered state only.
  - A push occurs when in_valid & in_ready.
  - in_data must stay stable while in_valid=1 and in_ready=0.
- Divider:
  - While enable=1 the counter runs 0..rate_div. The tick is asserted in the cycle the count equals rate_div, and the counter then returns to 0.
  - rate_div=0 gives a tick every clock.
  - While enable=0 the counter is forced to 0, no ticks occur, and `sample` holds its last value.
  - On re-enable, the first tick occurs rate_div+1 clocks later.
  - If rate_div changes mid-count to a value below the current count, the counter continues until it wraps at 2^DIV_WIDTH. No special handling is required; software changes rate only while disabled.
- Tick with fifo_level>0:
  - Pop the head; the next cycle has sample = head and sample_strobe = 1 for exactly one cycle.
- Tick with fifo_level=0:
  - The next cycle has sample = midscale, sample_strobe = 1, and underrun set to 1.
- No bypass path:
  - A word pushed in cycle N is poppable from cycle N+1.
  - A push and a tick on an empty FIFO in the same cycle therefore produce an underrun; the pushed word is kept and used at the next tick.
- Simultaneous push and pop:
  - fifo_level is unchanged; both pointers advance.
  - When full, in_ready=0, so a same-cycle pop frees one slot that becomes visible the next cycle.
- fifo_level update: +1 on push only, -1 on pop only, unchanged otherwise. The level never exceeds DEPTH and never goes below 0.
- underrun_clr: clears the flag. If an underrun event occurs in the same cycle, set wins and underrun stays 1.
- Latency: from the tick cycle to the new `sample` value is 1 clock.

Test Plan:
- Reset checks: hold reset=0 mid-stream with 5 words queued, then release.
  - Required: sample=0x80, fifo_level=0, underrun=0, in_ready=1.
  - Required: no sample_strobe until rate_div+1 clocks after enable.
- Basic stream: rate_div=3, enable=1, push 0x10, 0x20, 0x30.
  - Required: sample_strobe every 4 clocks; sample sequence 0x10, 0x20, 0x30, then 0x80 with underrun=1.
- Full and backpressure: enable=0, push 17 words 0x00..0x10.
  - Required: in_ready drops after word 16, fifo_level=16, word 0x10 is held off.
  - Then enable with rate_div=0: in_ready returns 1 clock after the first pop, and 0x10 is accepted.
- Empty-edge race: FIFO empty, push 0x55 in the same cycle as a tick.
  - Required: sample=0x80 and underrun=1; at the next tick sample=0x55.
- Sticky clear: pulse underrun_clr together with an underrun tick.
  - Required: underrun stays 1.
  - Then pulse underrun_clr alone: underrun=0 next cycle.
- Enable gating: stop enable mid-stream with sample=0x20 and 3 words queued.
  - Required: sample holds 0x20, no strobes, fifo_level stays 3 while enable=0.
